// File: rtl/pq_buffer_ctrl.sv
// ---------------------------------------------------------------------------
// pq_buffer_ctrl
//
// Sequencer for a two-bank ping-pong buffer. It owns the buffer's bank-select
// (buf_ctrl) and clear (buf_clear) inputs and arbitrates the buffer's two
// ports between the neuron-update core (producer) and the spike/packet stage
// (consumer).
//
//   * After reset both banks are zeroed by a DEPTH-cycle clear sweep (INIT).
//   * In RUN, port 1 is a gated pass-through that gives the producer random
//     read/write access to the current write bank.
//   * When the producer signals frame completion, the banks are swapped as
//     soon as the previous drain has finished. The just-completed bank is then
//     streamed out through port 2 in address order, and each word is
//     overwritten with zero one cycle after it is read, so the bank comes back
//     clean for the next frame.
//
// Port summary
//   clk, rst_n             clock, asynchronous active-low reset
//   p_ready                producer may use the write bank
//   p_rd_en/p_rd_addr      producer read of the write bank
//   p_rdata                producer read data (buf_dout1, one-cycle latency)
//   p_wr_en/p_wr_addr/p_din producer write of the write bank
//   p_frame_done           frame complete pulse, honoured only while p_ready
//   m_valid/m_ready        drain stream handshake
//   m_data/m_addr/m_last   drained word, its bank address, last-word flag
//   busy                   INIT running or drain not yet fully delivered
//   buf_ctrl/buf_clear     buffer bank select and clear
//   buf_*1                 buffer port 1 (producer side / clear sweep)
//   buf_*2                 buffer port 2 (drain side)
//   buf_dout1/buf_dout2    buffer read data
// ---------------------------------------------------------------------------
module pq_buffer_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,

   output logic                  p_ready,
   input  logic                  p_rd_en,
   input  logic [ADDR_WIDTH-1:0] p_rd_addr,
   output logic [DATA_WIDTH-1:0] p_rdata,
   input  logic                  p_wr_en,
   input  logic [ADDR_WIDTH-1:0] p_wr_addr,
   input  logic [DATA_WIDTH-1:0] p_din,
   input  logic                  p_frame_done,

   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic [ADDR_WIDTH-1:0] m_addr,
   output logic                  m_last,

   output logic                  busy,

   output logic                  buf_ctrl,
   output logic                  buf_clear,
   output logic                  buf_rd_en1,
   output logic [ADDR_WIDTH-1:0] buf_rd_addr1,
   output logic                  buf_wr_en1,
   output logic [ADDR_WIDTH-1:0] buf_wr_addr1,
   output logic [DATA_WIDTH-1:0] buf_din1,
   output logic                  buf_rd_en2,
   output logic [ADDR_WIDTH-1:0] buf_rd_addr2,
   output logic                  buf_wr_en2,
   output logic [ADDR_WIDTH-1:0] buf_wr_addr2,
   output logic [DATA_WIDTH-1:0] buf_din2,
   input  logic [DATA_WIDTH-1:0] buf_dout1,
   input  logic [DATA_WIDTH-1:0] buf_dout2
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t                  r_state;
   state_t                  w_stateNext;

   logic [ADDR_WIDTH-1:0]   r_initCnt;
   logic                    r_ctrl;
   logic                    r_pReady;
   logic                    r_framePend;
   logic                    r_drainDone;

   // One extra bit so that "all DEPTH addresses issued" is visible without
   // the counter wrapping back to zero inside a drain.
   logic [ADDR_WIDTH:0]     r_rdCnt;

   // Read issued last cycle: its data is on buf_dout2 now and its address is
   // being clear-written now.
   logic                    r_inflight;
   logic [ADDR_WIDTH-1:0]   r_inflightAddr;

   // Two-entry output FIFO, entry 0 is always the head.
   logic [DATA_WIDTH-1:0]   r_fifoData [2];
   logic [ADDR_WIDTH-1:0]   r_fifoAddr [2];
   logic [1:0]              r_fifoCnt;

   logic                    w_run;
   logic                    w_accept;
   logic                    w_swap;
   logic                    w_push;
   logic                    w_pop;
   logic [2:0]              w_occupancy;
   logic [2:0]              w_room;
   logic                    w_issue;
   logic                    w_lastClear;

   assign w_run    = (r_state == ST_RUN);
   assign w_accept = w_run && r_pReady && p_frame_done;
   assign w_swap   = w_run && r_framePend && r_drainDone;

   assign w_push = r_inflight;
   assign w_pop  = (r_fifoCnt != 2'd0) && m_ready;

   // Reads are only issued when the word they fetch is guaranteed a FIFO
   // slot. A pop in the current cycle frees a slot in time, which is what
   // keeps the stream at one word per cycle while m_ready stays high.
   assign w_occupancy = {1'b0, r_fifoCnt} + {2'b00, r_inflight};
   assign w_room      = 3'd2 + {2'b00, w_pop};
   assign w_issue     = w_run && !r_drainDone && !r_rdCnt[ADDR_WIDTH]
                        && (w_occupancy < w_room);

   assign w_lastClear = r_inflight && (r_inflightAddr == LAST_ADDR);

   // State register for the INIT/RUN sequencer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_INIT;
      end else begin
         r_state <= w_stateNext;
      end
   end

   // Next-state and buffer-port decode. INIT drives the clear sweep on port 1
   // with everything else idle; RUN gives port 1 to the producer (gated by
   // p_ready) and port 2 to the drain engine.
   always_comb begin
      w_stateNext  = r_state;
      buf_clear    = 1'b0;
      buf_rd_en1   = 1'b0;
      buf_rd_addr1 = '0;
      buf_wr_en1   = 1'b0;
      buf_wr_addr1 = '0;
      buf_din1     = '0;
      buf_rd_en2   = 1'b0;
      buf_rd_addr2 = '0;
      buf_wr_en2   = 1'b0;
      buf_wr_addr2 = '0;
      buf_din2     = '0;

      case (r_state)
         ST_INIT: begin
            buf_clear    = 1'b1;
            buf_wr_en1   = 1'b1;
            buf_wr_addr1 = r_initCnt;
            if (r_initCnt == LAST_ADDR) begin
               w_stateNext = ST_RUN;
            end
         end
         ST_RUN: begin
            buf_rd_en1   = p_rd_en && r_pReady;
            buf_rd_addr1 = p_rd_addr;
            buf_wr_en1   = p_wr_en && r_pReady;
            buf_wr_addr1 = p_wr_addr;
            buf_din1     = p_din;
            buf_rd_en2   = w_issue;
            buf_rd_addr2 = r_rdCnt[ADDR_WIDTH-1:0];
            buf_wr_en2   = r_inflight;
            buf_wr_addr2 = r_inflightAddr;
         end
         default: begin
            w_stateNext = ST_INIT;
         end
      endcase
   end

   // Frame bookkeeping: INIT sweep counter, bank select, producer ownership,
   // pending-frame and drain-complete flags, and the drain read counter.
   // A swap needs drain_done, and while drain_done is set no read is issued
   // and nothing is in flight, so the swap branch never competes with the
   // drain updates. An accept needs p_ready, which is never set together with
   // frame_pend, so accept and swap never coincide either.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_initCnt   <= '0;
         r_ctrl      <= 1'b0;
         r_pReady    <= 1'b0;
         r_framePend <= 1'b0;
         r_drainDone <= 1'b0;
         r_rdCnt     <= '0;
      end else if (r_state == ST_INIT) begin
         r_initCnt <= r_initCnt + 1'b1;
         if (r_initCnt == LAST_ADDR) begin
            r_pReady    <= 1'b1;
            r_drainDone <= 1'b1;
            r_framePend <= 1'b0;
         end
      end else if (w_swap) begin
         r_ctrl      <= !r_ctrl;
         r_framePend <= 1'b0;
         r_drainDone <= 1'b0;
         r_rdCnt     <= '0;
         r_pReady    <= 1'b1;
      end else begin
         if (w_accept) begin
            r_framePend <= 1'b1;
            r_pReady    <= 1'b0;
         end
         if (w_lastClear) begin
            r_drainDone <= 1'b1;
         end
         if (w_issue) begin
            r_rdCnt <= r_rdCnt + 1'b1;
         end
      end
   end

   // One-cycle delay of the issued read, matching the buffer read latency.
   // The delayed address both tags the returning word and drives the
   // clear-write behind it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_inflight     <= 1'b0;
         r_inflightAddr <= '0;
      end else begin
         r_inflight     <= w_issue;
         r_inflightAddr <= r_rdCnt[ADDR_WIDTH-1:0];
      end
   end

   // Output FIFO. The head never moves unless it is popped, which is what
   // keeps m_data/m_addr/m_last stable under backpressure. The issue throttle
   // guarantees a push never arrives while both entries are held.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fifoData[0] <= '0;
         r_fifoData[1] <= '0;
         r_fifoAddr[0] <= '0;
         r_fifoAddr[1] <= '0;
         r_fifoCnt     <= 2'd0;
      end else begin
         case ({w_push, w_pop})
            2'b10: begin
               r_fifoData[r_fifoCnt[0]] <= buf_dout2;
               r_fifoAddr[r_fifoCnt[0]] <= r_inflightAddr;
               r_fifoCnt                <= r_fifoCnt + 2'd1;
            end
            2'b01: begin
               r_fifoData[0] <= r_fifoData[1];
               r_fifoAddr[0] <= r_fifoAddr[1];
               r_fifoCnt     <= r_fifoCnt - 2'd1;
            end
            2'b11: begin
               if (r_fifoCnt == 2'd1) begin
                  r_fifoData[0] <= buf_dout2;
                  r_fifoAddr[0] <= r_inflightAddr;
               end else begin
                  r_fifoData[0] <= r_fifoData[1];
                  r_fifoAddr[0] <= r_fifoAddr[1];
                  r_fifoData[1] <= buf_dout2;
                  r_fifoAddr[1] <= r_inflightAddr;
               end
            end
            default: begin
               r_fifoCnt <= r_fifoCnt;
            end
         endcase
      end
   end

   assign m_valid  = (r_fifoCnt != 2'd0);
   assign m_data   = r_fifoData[0];
   assign m_addr   = r_fifoAddr[0];
   assign m_last   = m_valid && (r_fifoAddr[0] == LAST_ADDR);

   assign p_ready  = r_pReady;
   assign p_rdata  = buf_dout1;
   assign buf_ctrl = r_ctrl;

   // drain_done rises as soon as the last clear-write is done, so busy also
   // covers words still waiting in the FIFO.
   assign busy = (r_state == ST_INIT) || !r_drainDone || (r_fifoCnt != 2'd0);

endmodule

// File: tb/tb_pq_buffer_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pq_buffer_ctrl
//
// Directed bench for pq_buffer_ctrl with DEPTH=16, DATA_WIDTH=8. A behavioural
// two-bank buffer sits on the buf_* ports: port 1 reaches bank buf_ctrl,
// port 2 reaches the other bank, clear zeroes both banks at buf_wr_addr1,
// reads have one cycle of latency. Drained beats are captured on the falling
// edge and compared with hand-computed frame contents.
// ---------------------------------------------------------------------------
module tb_pq_buffer_ctrl;

   logic       clk;
   logic       rst_n;
   logic       p_rd_en;
   logic [3:0] p_rd_addr;
   logic       p_wr_en;
   logic [3:0] p_wr_addr;
   logic [7:0] p_din;
   logic       p_frame_done;
   logic       m_ready;
   logic [7:0] buf_dout1;
   logic [7:0] buf_dout2;

   logic       p_ready;
   logic [7:0] p_rdata;
   logic       m_valid;
   logic [7:0] m_data;
   logic [3:0] m_addr;
   logic       m_last;
   logic       busy;
   logic       buf_ctrl;
   logic       buf_clear;
   logic       buf_rd_en1;
   logic [3:0] buf_rd_addr1;
   logic       buf_wr_en1;
   logic [3:0] buf_wr_addr1;
   logic [7:0] buf_din1;
   logic       buf_rd_en2;
   logic [3:0] buf_rd_addr2;
   logic       buf_wr_en2;
   logic [3:0] buf_wr_addr2;
   logic [7:0] buf_din2;

   int checkCount = 0;
   int errorCount = 0;

   logic [7:0] mem [2][16];
   logic       fillReq;
   logic       otherBank;

   logic [3:0] capAddr [$];
   logic [7:0] capData [$];
   logic       capLast [$];
   logic       prevStall = 1'b0;
   logic [7:0] prevData  = 8'h00;
   logic [3:0] prevAddr  = 4'h0;
   logic       prevLast  = 1'b0;
   int         stallSeen = 0;
   int         stallBad  = 0;

   logic       bpMode = 1'b0;
   logic [3:0] bpPat  = 4'b1001;
   logic [1:0] bpIdx  = 2'd0;

   logic [7:0] expData [16];

   pq_buffer_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .p_ready      (p_ready),
      .p_rd_en      (p_rd_en),
      .p_rd_addr    (p_rd_addr),
      .p_rdata      (p_rdata),
      .p_wr_en      (p_wr_en),
      .p_wr_addr    (p_wr_addr),
      .p_din        (p_din),
      .p_frame_done (p_frame_done),
      .m_valid      (m_valid),
      .m_ready      (m_ready),
      .m_data       (m_data),
      .m_addr       (m_addr),
      .m_last       (m_last),
      .busy         (busy),
      .buf_ctrl     (buf_ctrl),
      .buf_clear    (buf_clear),
      .buf_rd_en1   (buf_rd_en1),
      .buf_rd_addr1 (buf_rd_addr1),
      .buf_wr_en1   (buf_wr_en1),
      .buf_wr_addr1 (buf_wr_addr1),
      .buf_din1     (buf_din1),
      .buf_rd_en2   (buf_rd_en2),
      .buf_rd_addr2 (buf_rd_addr2),
      .buf_wr_en2   (buf_wr_en2),
      .buf_wr_addr2 (buf_wr_addr2),
      .buf_din2     (buf_din2),
      .buf_dout1    (buf_dout1),
      .buf_dout2    (buf_dout2)
   );

   // Free-running clock, 10 time units per cycle.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Behavioural ping-pong buffer. fillReq preloads both banks with a
   // non-zero pattern so the INIT sweep has something to erase.
   assign otherBank = !buf_ctrl;

   always @(posedge clk) begin
      if (buf_rd_en1) buf_dout1 <= mem[buf_ctrl][buf_rd_addr1];
      if (buf_rd_en2) buf_dout2 <= mem[otherBank][buf_rd_addr2];
      if (fillReq) begin
         for (int i = 0; i < 16; i++) begin
            mem[0][i] <= 8'hEE;
            mem[1][i] <= 8'hEE;
         end
      end
      if (buf_clear) begin
         mem[0][buf_wr_addr1] <= 8'h00;
         mem[1][buf_wr_addr1] <= 8'h00;
      end else begin
         if (buf_wr_en1) mem[buf_ctrl][buf_wr_addr1]  <= buf_din1;
         if (buf_wr_en2) mem[otherBank][buf_wr_addr2] <= buf_din2;
      end
   end

   // Consumer ready: always high, or the repeating 1,0,0,1 pattern.
   initial begin
      m_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (bpMode) begin
            m_ready = bpPat[bpIdx];
            bpIdx   = bpIdx + 2'd1;
         end else begin
            m_ready = 1'b1;
         end
      end
   end

   // Stream monitor: records accepted beats and whether a stalled head word
   // changed before it was taken.
   always @(negedge clk) begin
      if (rst_n && m_valid && m_ready) begin
         capAddr.push_back(m_addr);
         capData.push_back(m_data);
         capLast.push_back(m_last);
      end
      if (rst_n && m_valid && prevStall) begin
         stallSeen++;
         if (m_data !== prevData || m_addr !== prevAddr || m_last !== prevLast) stallBad++;
      end
      prevStall = rst_n && m_valid && !m_ready;
      prevData  = m_data;
      prevAddr  = m_addr;
      prevLast  = m_last;
   end

   // Bound on the whole run in case a wait loop is ever bypassed.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Drives the producer inputs for exactly one cycle, then idles them.
   task automatic applyStimulus(input logic rdEn, input logic [3:0] rdAddr,
                                input logic wrEn, input logic [3:0] wrAddr,
                                input logic [7:0] din, input logic frameDone);
      p_rd_en      = rdEn;
      p_rd_addr    = rdAddr;
      p_wr_en      = wrEn;
      p_wr_addr    = wrAddr;
      p_din        = din;
      p_frame_done = frameDone;
      @(posedge clk);
      #1;
      p_rd_en      = 1'b0;
      p_wr_en      = 1'b0;
      p_frame_done = 1'b0;
   endtask

   function automatic int countNonZero(input int bank);
      int n = 0;
      for (int i = 0; i < 16; i++) if (mem[bank][i] !== 8'h00) n++;
      return n;
   endfunction

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_ctrl"},     buf_ctrl,     0);
      checkOutput({tag, "_clear"},    buf_clear,    1);
      checkOutput({tag, "_p_ready"},  p_ready,      0);
      checkOutput({tag, "_m_valid"},  m_valid,      0);
      checkOutput({tag, "_busy"},     busy,         1);
      checkOutput({tag, "_rd_en1"},   buf_rd_en1,   0);
      checkOutput({tag, "_rd_en2"},   buf_rd_en2,   0);
      checkOutput({tag, "_wr_en2"},   buf_wr_en2,   0);
      checkOutput({tag, "_wr_addr1"}, buf_wr_addr1, 0);
      checkOutput({tag, "_rd_addr2"}, buf_rd_addr2, 0);
   endtask

   // Called just after reset release: expects one clear per cycle over
   // addresses 0..15, then RUN with both banks zero.
   task automatic checkInitSweep(input string tag);
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         checkOutput($sformatf("%s_clear%0d", tag, i), buf_clear, 1);
         checkOutput($sformatf("%s_addr%0d", tag, i), buf_wr_addr1, i);
      end
      @(negedge clk);
      checkOutput({tag, "_clear_done"}, buf_clear, 0);
      checkOutput({tag, "_p_ready"},    p_ready,   1);
      checkOutput({tag, "_busy"},       busy,      0);
      checkOutput({tag, "_bank0_zero"}, countNonZero(0), 0);
      checkOutput({tag, "_bank1_zero"}, countNonZero(1), 0);
   endtask

   task automatic waitBeats(input int target, input string tag);
      int cyc = 0;
      while (capAddr.size() < target && cyc < 400) begin
         @(posedge clk);
         cyc++;
      end
      #1;
      checkOutput({tag, "_beats_arrived"}, capAddr.size() >= target, 1);
   endtask

   task automatic checkBeats(input int base, input string tag);
      for (int i = 0; i < 16; i++) begin
         if (base + i < capAddr.size()) begin
            checkOutput($sformatf("%s_addr%0d", tag, i), capAddr[base+i], i);
            checkOutput($sformatf("%s_data%0d", tag, i), capData[base+i], expData[i]);
            checkOutput($sformatf("%s_last%0d", tag, i), capLast[base+i], i == 15);
         end
      end
   endtask

   task automatic waitRdAddr(input logic [3:0] a, output bit found);
      found = 1'b0;
      for (int c = 0; c < 64 && !found; c++) begin
         @(posedge clk);
         #1;
         if (buf_rd_en2 && buf_rd_addr2 == a) found = 1'b1;
      end
   endtask

   task automatic accumulate4(input string tag);
      logic [7:0] v;
      for (int k = 0; k < 4; k++) begin
         applyStimulus(1'b1, 4'd2, 1'b0, 4'd0, 8'h00, 1'b0);
         v = p_rdata;
         if (k == 0) checkOutput({tag, "_first_read"}, v, 0);
         applyStimulus(1'b0, 4'd0, 1'b1, 4'd2, v + 8'd1, 1'b0);
      end
   endtask

   initial begin
      int  base;
      int  clrCyc;
      int  riseCyc;
      bit  found;
      logic [7:0] v;

      fillReq      = 1'b1;
      rst_n        = 1'b0;
      p_rd_en      = 1'b0;
      p_rd_addr    = 4'd0;
      p_wr_en      = 1'b0;
      p_wr_addr    = 4'd0;
      p_din        = 8'h00;
      p_frame_done = 1'b0;

      // Reset and INIT sweep.
      @(posedge clk);
      #1;
      fillReq = 1'b0;
      @(negedge clk);
      checkResetState("rst1");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      checkInitSweep("init1");

      // Single frame, consumer always ready.
      checkOutput("t2_ctrl_before", buf_ctrl, 0);
      @(posedge clk);
      #1;
      applyStimulus(1'b0, 4'd0, 1'b1, 4'd3,  8'h11, 1'b0);
      applyStimulus(1'b0, 4'd0, 1'b1, 4'd15, 8'hAB, 1'b0);
      base = capAddr.size();
      applyStimulus(1'b0, 4'd0, 1'b0, 4'd0, 8'h00, 1'b1);
      @(negedge clk);
      checkOutput("t2_ready_dropped", p_ready, 0);
      checkOutput("t2_ctrl_pre_swap", buf_ctrl, 0);
      @(negedge clk);
      checkOutput("t2_ctrl_swapped", buf_ctrl, 1);
      checkOutput("t2_first_rd_en", buf_rd_en2, 1);
      checkOutput("t2_first_rd_addr", buf_rd_addr2, 0);
      checkOutput("t2_ready_back", p_ready, 1);
      checkOutput("t2_busy", busy, 1);
      @(negedge clk);
      checkOutput("t2_valid_s1", m_valid, 0);
      checkOutput("t2_clear_en", buf_wr_en2, 1);
      checkOutput("t2_clear_addr", buf_wr_addr2, 0);
      checkOutput("t2_clear_din", buf_din2, 0);
      @(negedge clk);
      checkOutput("t2_valid_s2", m_valid, 1);
      checkOutput("t2_head_addr", m_addr, 0);
      waitBeats(base + 16, "t2");
      for (int i = 0; i < 16; i++) expData[i] = 8'h00;
      expData[3]  = 8'h11;
      expData[15] = 8'hAB;
      checkBeats(base, "t2");
      repeat (3) @(posedge clk);
      #1;
      checkOutput("t2_busy_end", busy, 0);
      checkOutput("t2_bank0_clean", countNonZero(0), 0);

      // Same frame shape under a 1,0,0,1 ready pattern.
      bpMode = 1'b1;
      applyStimulus(1'b0, 4'd0, 1'b1, 4'd0,  8'h5A, 1'b0);
      applyStimulus(1'b0, 4'd0, 1'b1, 4'd7,  8'h33, 1'b0);
      applyStimulus(1'b0, 4'd0, 1'b1, 4'd15, 8'hC3, 1'b0);
      base = capAddr.size();
      applyStimulus(1'b0, 4'd0, 1'b0, 4'd0, 8'h00, 1'b1);
      waitBeats(base + 16, "t3");
      bpMode = 1'b0;
      for (int i = 0; i < 16; i++) expData[i] = 8'h00;
      expData[0]  = 8'h5A;
      expData[7]  = 8'h33;
      expData[15] = 8'hC3;
      checkBeats(base, "t3");
      checkOutput("t3_beat_total", capAddr.size() - base, 16);
      checkOutput("t3_stalls_seen", stallSeen > 0, 1);
      checkOutput("t3_stall_unstable", stallBad, 0);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("t3_ctrl", buf_ctrl, 0);
      checkOutput("t3_bank1_clean", countNonZero(1), 0);

      // Second frame_done arrives mid-drain of the first.
      applyStimulus(1'b0, 4'd0, 1'b1, 4'd5,  8'h55, 1'b0);
      applyStimulus(1'b0, 4'd0, 1'b1, 4'd15, 8'h0F, 1'b0);
      base = capAddr.size();
      applyStimulus(1'b0, 4'd0, 1'b0, 4'd0, 8'h00, 1'b1);
      applyStimulus(1'b0, 4'd0, 1'b0, 4'd0, 8'h00, 1'b0);
      applyStimulus(1'b0, 4'd0, 1'b1, 4'd1, 8'h21, 1'b0);
      applyStimulus(1'b0, 4'd0, 1'b1, 4'd9, 8'h99, 1'b0);
      waitRdAddr(4'd5, found);
      checkOutput("t4_reached_addr5", found, 1);
      applyStimulus(1'b0, 4'd0, 1'b0, 4'd0, 8'h00, 1'b1);
      clrCyc  = -100;
      riseCyc = -1;
      for (int c = 0; c < 64 && riseCyc < 0; c++) begin
         @(negedge clk);
         if (buf_wr_en2 && !buf_clear && buf_wr_addr2 == 4'd15) clrCyc = c;
         if (p_ready) riseCyc = c;
      end
      checkOutput("t4_ready_rose", riseCyc >= 0, 1);
      checkOutput("t4_ready_gap_after_clear15", riseCyc - clrCyc, 2);
      checkOutput("t4_ctrl_second_swap", buf_ctrl, 0);
      waitBeats(base + 32, "t4");
      for (int i = 0; i < 16; i++) expData[i] = 8'h00;
      expData[5]  = 8'h55;
      expData[15] = 8'h0F;
      checkBeats(base, "t4f1");
      for (int i = 0; i < 16; i++) expData[i] = 8'h00;
      expData[1] = 8'h21;
      expData[9] = 8'h99;
      checkBeats(base + 16, "t4f2");

      // Reset in the middle of a drain.
      applyStimulus(1'b0, 4'd0, 1'b1, 4'd8,  8'h88, 1'b0);
      applyStimulus(1'b0, 4'd0, 1'b1, 4'd12, 8'hCC, 1'b0);
      applyStimulus(1'b0, 4'd0, 1'b0, 4'd0, 8'h00, 1'b1);
      waitRdAddr(4'd8, found);
      checkOutput("t5_reached_addr8", found, 1);
      rst_n = 1'b0;
      @(negedge clk);
      checkResetState("rst2");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      checkInitSweep("init2");

      // Read-accumulate over two frames.
      @(posedge clk);
      #1;
      accumulate4("t6a");
      base = capAddr.size();
      applyStimulus(1'b0, 4'd0, 1'b0, 4'd0, 8'h00, 1'b1);
      waitBeats(base + 16, "t6a");
      for (int i = 0; i < 16; i++) expData[i] = 8'h00;
      expData[2] = 8'h04;
      checkBeats(base, "t6a");
      applyStimulus(1'b0, 4'd0, 1'b0, 4'd0, 8'h00, 1'b0);
      accumulate4("t6b");
      base = capAddr.size();
      applyStimulus(1'b0, 4'd0, 1'b0, 4'd0, 8'h00, 1'b1);
      waitBeats(base + 16, "t6b");
      checkBeats(base, "t6b");
      applyStimulus(1'b0, 4'd0, 1'b0, 4'd0, 8'h00, 1'b0);
      checkOutput("t6_ctrl_back", buf_ctrl, 0);
      applyStimulus(1'b1, 4'd2, 1'b0, 4'd0, 8'h00, 1'b0);
      v = p_rdata;
      checkOutput("t6_reused_bank_read", v, 0);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
